// File: rtl/pc_sequencer.sv
// rtl/pc_sequencer.sv - parametrised program-counter sequencer for the fetch stage
//
// Purpose: holds the current fetch address and selects the next one from a
// sequential step, PC-relative branch, absolute jump, trap or halt request.
// All state advances on the falling edge of CLK.
//
// Optional feature macro: BRANCH_DELAY_SLOT_EN. When it is defined, an aligned
// redirect first steps into a delay-slot instruction and loads the target on
// the following non-stalled edge.
//
// Ports:
//   CLK            in   clock, state updates on the falling edge
//   MasterReset_L  in   asynchronous active-low reset
//   Stall          in   hold PC (Trap overrides)
//   BranchTaken    in   PC-relative redirect request
//   BranchOffset   in   signed byte offset added to the current PC
//   Jump           in   absolute redirect request (wins over BranchTaken)
//   JumpTarget     in   absolute redirect target
//   Trap           in   redirect to TRAP_VEC, highest priority
//   Halt           in   enter the halted state
//   PC             out  current fetch address
//   Link           out  PC + STEP, combinational, wraps
//   Valid          out  PC is a fetchable address this cycle
//   Misaligned     out  sticky: a redirect target was not STEP-aligned

module pc_sequencer #(
  parameter int unsigned       WIDTH    = 32,
  parameter int unsigned       STEP     = 4,
  parameter logic [WIDTH-1:0]  RESET_PC = '0,
  parameter logic [WIDTH-1:0]  TRAP_VEC = WIDTH'('h80)
) (
  input  logic             CLK,
  input  logic             MasterReset_L,
  input  logic             Stall,
  input  logic             BranchTaken,
  input  logic [WIDTH-1:0] BranchOffset,
  input  logic             Jump,
  input  logic [WIDTH-1:0] JumpTarget,
  input  logic             Trap,
  input  logic             Halt,
  output logic [WIDTH-1:0] PC,
  output logic [WIDTH-1:0] Link,
  output logic             Valid,
  output logic             Misaligned
);

  // STEP is a power of two, so alignment is a test of the low bits.
  localparam logic [WIDTH-1:0] ALIGN_MASK = WIDTH'(STEP - 1);
  localparam logic [WIDTH-1:0] STEP_W     = WIDTH'(STEP);

`ifdef BRANCH_DELAY_SLOT_EN
  typedef enum logic [1:0] {START, RUN, DELAY, HALTED} state_t;
`else
  typedef enum logic [1:0] {START, RUN, HALTED} state_t;
`endif

  state_t           state, state_nxt;
  logic [WIDTH-1:0] pc, pc_nxt;
  logic             misaligned, misaligned_nxt;
  logic [WIDTH-1:0] redirect_target;
  logic             redirect_req;
  logic             redirect_bad;

`ifdef BRANCH_DELAY_SLOT_EN
  logic [WIDTH-1:0] pending, pending_nxt;
`endif

  // Jump wins over a simultaneous branch; the branch is simply dropped.
  assign redirect_req    = Jump | BranchTaken;
  assign redirect_target = Jump ? JumpTarget : (pc + BranchOffset);
  assign redirect_bad    = |(redirect_target & ALIGN_MASK);

  always_ff @(negedge CLK or negedge MasterReset_L) begin
    if (!MasterReset_L) begin
      state      <= START;
      pc         <= RESET_PC;
      misaligned <= 1'b0;
`ifdef BRANCH_DELAY_SLOT_EN
      pending    <= '0;
`endif
    end else begin
      state      <= state_nxt;
      pc         <= pc_nxt;
      misaligned <= misaligned_nxt;
`ifdef BRANCH_DELAY_SLOT_EN
      pending    <= pending_nxt;
`endif
    end
  end

  always_comb begin
    state_nxt      = state;
    pc_nxt         = pc;
    misaligned_nxt = misaligned;
`ifdef BRANCH_DELAY_SLOT_EN
    pending_nxt    = pending;
`endif
    case (state)
      // RESET_PC is the first fetch: leave START without touching PC.
      START: state_nxt = RUN;

      RUN: begin
        if (Trap) begin
          pc_nxt = TRAP_VEC;
        end else if (Halt) begin
          state_nxt = HALTED;
        end else if (Stall) begin
          pc_nxt = pc;
        end else if (redirect_req) begin
          if (redirect_bad) begin
            // Misaligned targets trap at once, never through a delay slot.
            misaligned_nxt = 1'b1;
            pc_nxt         = TRAP_VEC;
          end else begin
`ifdef BRANCH_DELAY_SLOT_EN
            pc_nxt      = pc + STEP_W;
            pending_nxt = redirect_target;
            state_nxt   = DELAY;
`else
            pc_nxt = redirect_target;
`endif
          end
        end else begin
          pc_nxt = pc + STEP_W;
        end
      end

`ifdef BRANCH_DELAY_SLOT_EN
      // Halt, Jump and Branch are ignored here; a held Halt is seen again
      // once back in RUN, which is what defers it past the target load.
      DELAY: begin
        if (Trap) begin
          pc_nxt    = TRAP_VEC;
          state_nxt = RUN;
        end else if (!Stall) begin
          pc_nxt    = pending;
          state_nxt = RUN;
        end
      end
`endif

      HALTED: begin
        if (Trap) begin
          pc_nxt    = TRAP_VEC;
          state_nxt = RUN;
        end
      end

      default: state_nxt = START;
    endcase
  end

  assign PC         = pc;
  assign Link       = pc + STEP_W;
  assign Misaligned = misaligned;
`ifdef BRANCH_DELAY_SLOT_EN
  assign Valid      = (state == RUN) || (state == DELAY);
`else
  assign Valid      = (state == RUN);
`endif

endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Parametrised program-counter sequencer for the fetch stage: holds the current instruction address and computes the next one from sequential step, PC-relative branch, absolute jump, trap or halt requests. It generalises the fixed 32-bit/+4 counter with configurable width, step and vectors, stall, redirect priority, misalignment trapping and an optional branch delay slot. It drives instruction-memory addressing and supplies the link address to the register-file write path.

## Interface
Parameters:
- WIDTH, 32, address width in bits
- STEP, 4, bytes per instruction; power of two, at least 1
- RESET_PC, 0, first fetch address after reset; multiple of STEP
- TRAP_VEC, 32'h80, trap handler address; multiple of STEP

Ports:
- CLK  in  1  clock; all state updates on the falling edge
- MasterReset_L  in  1  asynchronous, active-low reset
- Stall  in  1  hold PC (Trap overrides)
- BranchTaken  in  1  PC-relative redirect request
- BranchOffset  in  WIDTH  signed byte offset added to current PC
- Jump  in  1  absolute redirect request
- JumpTarget  in  WIDTH  absolute target
- Trap  in  1  redirect to TRAP_VEC
- Halt  in  1  enter HALTED
- PC  out  WIDTH  current fetch address
- Link  out  WIDTH  PC + STEP, combinational, wraps mod 2^WIDTH
- Valid  out  1  PC is a fetchable address this cycle
- Misaligned  out  1  sticky flag: a redirect target was not STEP-aligned

## Operation
- States: START, RUN, DELAY (macro only), HALTED.
- Reset (MasterReset_L low, async): state START, PC=RESET_PC, Valid=0, Misaligned=0, pending target cleared.
- START: first falling edge after release -> RUN, Valid=1, PC unchanged, so RESET_PC is the first fetch.
- RUN, per edge, priority Trap > Halt > Stall > Jump > BranchTaken > step:
  - Trap: PC=TRAP_VEC. Applies even when Stall=1.
  - Halt: -> HALTED, Valid=0, PC held.
  - Stall: PC held.
  - Jump: target=JumpTarget.
  - BranchTaken: target=PC+BranchOffset, truncated to WIDTH.
  - Neither request: PC=PC+STEP, wrapping to 0 past 2^WIDTH-1.
- Alignment check: applies to Jump and BranchTaken targets. If target mod STEP != 0, set Misaligned and load PC=TRAP_VEC instead of the target. Misaligned clears only on reset.
- Jump and BranchTaken asserted together: Jump wins and the branch is dropped.
- HALTED: PC held, Valid=0, all inputs ignored except Trap. Trap -> RUN with PC=TRAP_VEC and Valid=1.

## Timing
- Redirect latency: new PC is visible after the falling edge on which the request is sampled, one edge without delay slot.
- Inputs must be stable from 2 ns before the falling edge. PC updates at clock-to-q, not at a delayed #2.
- Link follows PC combinationally and has zero latency.
- Reset asserted mid-operation, including in DELAY or HALTED, takes effect immediately and discards any pending target.
- One redirect is accepted per edge. There is no queuing.

## Configuration
- BRANCH_DELAY_SLOT_EN defined:
  - An accepted, aligned Jump or Branch in RUN sets PC=PC+STEP (the delay-slot instruction), latches the target and enters DELAY.
  - DELAY: the next non-stalled edge loads the latched target and returns to RUN.
  - Stall in DELAY holds both PC and the latched target.
  - Jump or Branch in DELAY is ignored.
  - Trap in DELAY cancels the pending target and loads TRAP_VEC.
  - Halt in DELAY is deferred until the target has loaded.
  - Misaligned targets trap immediately, with no delay slot.
- BRANCH_DELAY_SLOT_EN undefined: the DELAY state does not exist, and redirects load the target directly.

## Test plan
- Reset release with defaults -> PC=0, Valid=0; after edge 1 Valid=1 with PC=0; edges 2 and 3 give PC=4, then 8; Link=PC+4 throughout.
- PC=0x10, BranchTaken, BranchOffset=-8 -> PC=0x08. JumpTarget=0x1002 -> PC=0x80 and Misaligned=1, which stays set after further redirects.
- Stall=1 for 3 edges at PC=0x20 -> PC stays 0x20. Stall and Trap together -> PC=0x80.
- WIDTH=8, PC=0xFC, no requests -> PC=0x00. Jump=1, BranchTaken=1, JumpTarget=0x40 -> PC=0x40.
- Halt at PC=0x30 -> Valid=0 and PC frozen for 5 edges with Jump toggling. Trap -> PC=0x80, Valid=1.
- With BRANCH_DELAY_SLOT_EN, Jump to 0x100 at PC=0x40 -> PC=0x44, then 0x100. A repeat with reset asserted while in DELAY -> PC=RESET_PC, and the pending target is lost.
